hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: PC_W, 32, width of ex_target and pc_target.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 ex_flush  input  1  branch-taken/jump flag from the EX-stage ALU.
REQ-005 ex_target  input  PC_W  redirect PC computed in EX.
REQ-006 id_rs1, id_rs2  input  5 each  source register indices of the ID instruction.
REQ-007 id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads rs1/rs2.
REQ-008 ex_rd  input  5  destination register of the EX instruction.
REQ-009 ex_memread  input  1  EX instruction is a load.
REQ-010 mem_busy  input  1  data memory not ready; whole pipeline must freeze.
REQ-011 pc_en, ifid_en, idex_en, exmem_en  output  1 each  stage register write enables.
REQ-012 ifid_clr, idex_clr  output  1 each  synchronous bubble insert into IF/ID, ID/EX.
REQ-013 pc_redirect  output  1  PC mux selects pc_target this cycle.
REQ-014 pc_target  output  PC_W  redirect address.
REQ-015 stall_cycles, flush_count  output  32 each  performance counters.

Function
REQ-016 Outputs are combinational from state and inputs; state is registered.
REQ-017 States: RUN, LDSTALL, WAIT, REDIR; priority per cycle: mem_busy > redirect > load-use.
REQ-018 Load-use = ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-019 Default (RUN, no event): all four enables 1, clears 0, pc_redirect 0, pc_target = ex_target.
REQ-020 RUN, mem_busy=1: all enables 0, clears 0, redirect 0; latch pend_valid=ex_flush, pend_target=ex_target; next WAIT.
REQ-021 RUN, mem_busy=0, ex_flush=1: pc_redirect=1, pc_target=ex_target, ifid_clr=1, idex_clr=1, enables 1; stay RUN; load-use ignored.
REQ-022 RUN, load-use, no busy/flush: pc_en=0, ifid_en=0, idex_clr=1, idex_en=1, exmem_en=1; next LDSTALL.
REQ-023 LDSTALL: default outputs; load-use check suppressed; ex_flush and mem_busy handled as in RUN; next RUN (or WAIT on busy).
REQ-024 WAIT: all enables 0, clears 0, redirect 0; ex_flush/ex_target ignored; stay while mem_busy=1.
REQ-025 WAIT, mem_busy=0: next REDIR if pend_valid else RUN; outputs this cycle remain frozen.
REQ-026 REDIR: pc_redirect=1, pc_target=pend_target, ifid_clr=1, idex_clr=1, enables 1; clear pend_valid; next RUN; mem_busy=1 in REDIR gives WAIT-style freeze, stays REDIR.
REQ-027 Exactly one redirect per taken branch, including when busy and flush coincide.

Reset
REQ-028 rstn=0 forces state RUN, pend_valid=0, pend_target=0, counters 0, immediately (no clock).
REQ-029 While rstn=0: all enables 0, clears 0, pc_redirect 0, pc_target 0.
REQ-030 Reset mid-WAIT or mid-REDIR discards the pending redirect.

Configuration
REQ-031 Macro HAZARD_PERF_EN defined: stall_cycles +1 each cycle pc_en=0 (rstn=1); flush_count +1 each cycle pc_redirect=1; both saturate at 32'hFFFFFFFF.
REQ-032 HAZARD_PERF_EN undefined: ports kept, both tied to 0, no counter flops.

Verification
REQ-033 Load x5 in EX, ID reads rs1=x5 -> one cycle pc_en=0, idex_clr=1, then normal; ex_rd=0 -> no stall.
REQ-034 ex_flush=1, ex_target=0x0000_0100 -> same cycle pc_redirect=1, pc_target=0x100, ifid_clr=idex_clr=1.
REQ-035 ex_flush=1 with mem_busy=1 for 3 cycles, ex_target=0x200 then changed -> 3 frozen cycles, 1 frozen exit cycle, REDIR to 0x200 once.
REQ-036 Load-use and ex_flush same cycle -> redirect only, no stall, state stays RUN.
REQ-037 rstn low during WAIT with pending redirect -> outputs zero at once; after release default RUN, no redirect.
REQ-038 HAZARD_PERF_EN: 2 load-use stalls + 3 busy cycles + 1 flush -> stall_cycles=5, flush_count=1; undefined -> both 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a classic five-stage in-order core. It
// arbitrates, once per cycle, between three events in fixed priority:
//   1. mem_busy : data memory not ready -> freeze every stage register
//   2. redirect : taken branch/jump from EX -> redirect PC, squash IF/ID, ID/EX
//   3. load-use : ID reads the register a load in EX is still producing
//                 -> hold PC and IF/ID for one cycle, bubble into ID/EX
//
// A branch that resolves while memory is busy cannot redirect during the
// freeze. Its target is captured and replayed exactly once, in the REDIR state,
// after the freeze ends.
//
// Optional feature (macro HAZARD_PERF_EN):
//   defined   : stall_cycles counts cycles with pc_en=0 and flush_count counts
//               cycles with pc_redirect=1. Both counters saturate at all-ones.
//   undefined : both counter ports are tied to zero and no counter flops exist.
//
// Ports
//   clk                    clock, rising edge
//   rstn                   asynchronous active-low reset
//   ex_flush, ex_target    taken-branch flag and redirect PC from EX
//   id_rs1, id_rs2         source register indices of the instruction in ID
//   id_use_rs1, id_use_rs2 ID instruction actually reads rs1 / rs2
//   ex_rd, ex_memread      destination register of EX; EX holds a load
//   mem_busy               data memory stall request
//   pc_en, ifid_en,
//   idex_en, exmem_en      stage register write enables
//   ifid_clr, idex_clr     synchronous bubble insert
//   pc_redirect, pc_target PC mux select and redirect address
//   stall_cycles,
//   flush_count            performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_flush,
    input  logic [PC_W-1:0] ex_target,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_memread,
    input  logic            mem_busy,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            ifid_clr,
    output logic            idex_clr,
    output logic            pc_redirect,
    output logic [PC_W-1:0] pc_target,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
);

    typedef enum logic [1:0] {
        RUN,
        LDSTALL,
        WAIT,
        REDIR
    } state_t;

    state_t          state_reg, state_next;
    logic            pend_valid_reg, pend_valid_next;
    logic [PC_W-1:0] pend_target_reg, pend_target_next;
    logic            load_use;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= RUN;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pend_valid_reg  <= pend_valid_next;
            pend_target_reg <= pend_target_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pend_valid_next  = pend_valid_reg;
        pend_target_next = pend_target_reg;
        pc_en            = 1'b1;
        ifid_en          = 1'b1;
        idex_en          = 1'b1;
        exmem_en         = 1'b1;
        ifid_clr         = 1'b0;
        idex_clr         = 1'b0;
        pc_redirect      = 1'b0;
        pc_target        = ex_target;

        case (state_reg)
            RUN, LDSTALL: begin
                if (mem_busy) begin
                    // Freeze; remember any branch resolving this cycle so it
                    // can be replayed once memory is ready again.
                    pc_en            = 1'b0;
                    ifid_en          = 1'b0;
                    idex_en          = 1'b0;
                    exmem_en         = 1'b0;
                    pend_valid_next  = ex_flush;
                    pend_target_next = ex_target;
                    state_next       = WAIT;
                end else if (ex_flush) begin
                    // The redirect squashes ID anyway, so a concurrent
                    // load-use hazard needs no stall.
                    pc_redirect = 1'b1;
                    ifid_clr    = 1'b1;
                    idex_clr    = 1'b1;
                    state_next  = RUN;
                end else if ((state_reg == RUN) && load_use) begin
                    // In LDSTALL the load has moved on to MEM, so the same
                    // ID instruction must not be stalled a second time.
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_clr   = 1'b1;
                    state_next = LDSTALL;
                end else begin
                    state_next = RUN;
                end
            end

            WAIT: begin
                // The exit cycle stays frozen too; the replay happens in REDIR.
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                if (!mem_busy) begin
                    state_next = pend_valid_reg ? REDIR : RUN;
                end
            end

            REDIR: begin
                if (mem_busy) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                end else begin
                    pc_redirect     = 1'b1;
                    pc_target       = pend_target_reg;
                    ifid_clr        = 1'b1;
                    idex_clr        = 1'b1;
                    pend_valid_next = 1'b0;
                    state_next      = RUN;
                end
            end

            default: begin
                state_next = RUN;
            end
        endcase

        // Everything quiet while reset is held, independent of the clock.
        if (!rstn) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_clr    = 1'b0;
            idex_clr    = 1'b0;
            pc_redirect = 1'b0;
            pc_target   = '0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!pc_en && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (pc_redirect && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_count  = flush_cnt_reg;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed testbench for hazard_ctrl. Inputs change on the falling edge and
// the combinational outputs are sampled 1 ns later, so every sample sits half
// a period away from the rising edge that advances the state.
// Control outputs are packed as
//   {pc_en, ifid_en, idex_en, exmem_en, ifid_clr, idex_clr, pc_redirect}.
// Counter expectations follow HAZARD_PERF_EN.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk;
    logic        rstn;
    logic        ex_flush;
    logic [31:0] ex_target;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_memread;
    logic        mem_busy;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        ifid_clr;
    logic        idex_clr;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    logic [6:0]  ctl;
    int          total;
    int          bad;

    localparam logic [6:0] RST_CTL = 7'b0000_000;
    localparam logic [6:0] DEF     = 7'b1111_000;
    localparam logic [6:0] FREEZE  = 7'b0000_000;
    localparam logic [6:0] FLUSH   = 7'b1111_111;
    localparam logic [6:0] LDU     = 7'b0011_010;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    hazard_ctrl #(.PC_W(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ex_flush     (ex_flush),
        .ex_target    (ex_target),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .ifid_clr     (ifid_clr),
        .idex_clr     (idex_clr),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, ifid_clr, idex_clr, pc_redirect};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [6:0] ctl_exp, input logic [31:0] tgt_exp);
        #1;
        check_val({tag, ".ctl"}, {25'd0, ctl}, {25'd0, ctl_exp});
        check_val({tag, ".tgt"}, pc_target, tgt_exp);
    endtask

    task automatic expect_cnt(input string tag, input int stalls, input int flushes);
        check_val({tag, ".stall"}, stall_cycles, PERF ? 32'(stalls) : 32'd0);
        check_val({tag, ".flush"}, flush_count, PERF ? 32'(flushes) : 32'd0);
    endtask

    task automatic idle();
        ex_flush   = 1'b0;
        mem_busy   = 1'b0;
        ex_memread = 1'b0;
        ex_rd      = 5'd0;
        id_rs1     = 5'd0;
        id_rs2     = 5'd0;
        id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0;
    endtask

    task automatic load_use_rs1(input logic [4:0] r);
        ex_memread = 1'b1;
        ex_rd      = r;
        id_rs1     = r;
        id_use_rs1 = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstn  = 1'b0;
        idle();
        ex_target = 32'h44;

        // Reset state
        expect_out("reset", RST_CTL, 32'h0);
        expect_cnt("reset", 0, 0);
        step();
        step(); rstn = 1'b1;                       expect_out("run_default", DEF, 32'h44);

        // Load-use on rs1, one stall, then suppressed in LDSTALL
        step(); load_use_rs1(5'd5);                expect_out("ldu_rs1", LDU, 32'h44);
        step();                                    expect_out("ldstall_suppress", DEF, 32'h44);
        step(); idle();                            expect_out("after_ldu", DEF, 32'h44);
        step(); load_use_rs1(5'd0);                expect_out("ldu_x0", DEF, 32'h44);
        step(); load_use_rs1(5'd9); id_use_rs1 = 1'b0;
                                                   expect_out("ldu_not_used", DEF, 32'h44);
        step(); idle(); ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
                                                   expect_out("ldu_rs2", LDU, 32'h44);
        step(); idle();                            expect_out("after_ldu_rs2", DEF, 32'h44);

        // Plain taken branch
        step(); ex_flush = 1'b1; ex_target = 32'h100;
                                                   expect_out("flush", FLUSH, 32'h100);
        step(); idle();                            expect_out("after_flush", DEF, 32'h100);

        // Load-use and flush together: redirect only, state stays RUN
        step(); ex_flush = 1'b1; ex_target = 32'h180; load_use_rs1(5'd5);
                                                   expect_out("flush_ldu", FLUSH, 32'h180);
        step(); ex_flush = 1'b0;                   expect_out("still_run", LDU, 32'h180);
        step(); idle();                            expect_out("ldstall_def", DEF, 32'h180);
        step();                                    expect_out("idle", DEF, 32'h180);
        expect_cnt("cnt_a", 3, 2);

        // Flush coinciding with busy: 3 frozen, 1 frozen exit, single replay
        step(); mem_busy = 1'b1; ex_flush = 1'b1; ex_target = 32'h200;
                                                   expect_out("busy_flush", FREEZE, 32'h200);
        step(); ex_target = 32'h300;               expect_out("wait1", FREEZE, 32'h300);
        step(); ex_flush = 1'b0; ex_target = 32'h304;
                                                   expect_out("wait2", FREEZE, 32'h304);
        step(); mem_busy = 1'b0; ex_target = 32'h400;
                                                   expect_out("wait_exit", FREEZE, 32'h400);
        step();                                    expect_out("redir", FLUSH, 32'h200);
        step();                                    expect_out("after_redir", DEF, 32'h400);

        // Busy returns while in REDIR: redirect is held off, not lost
        step(); mem_busy = 1'b1; ex_flush = 1'b1; ex_target = 32'h240;
                                                   expect_out("busy_flush2", FREEZE, 32'h240);
        step(); mem_busy = 1'b0; ex_flush = 1'b0; ex_target = 32'h400;
                                                   expect_out("wait_exit2", FREEZE, 32'h400);
        step(); mem_busy = 1'b1;                   expect_out("redir_busy", FREEZE, 32'h400);
        step(); mem_busy = 1'b0;                   expect_out("redir_late", FLUSH, 32'h240);
        step();                                    expect_out("after_redir2", DEF, 32'h400);

        // Busy without a branch: no redirect afterwards
        step(); mem_busy = 1'b1;                   expect_out("busy_only", FREEZE, 32'h400);
        step(); mem_busy = 1'b0;                   expect_out("busy_exit", FREEZE, 32'h400);
        step();                                    expect_out("busy_no_redir", DEF, 32'h400);
        expect_cnt("cnt_b", 12, 4);

        // Reset while waiting with a pending redirect
        step(); mem_busy = 1'b1; ex_flush = 1'b1; ex_target = 32'h500;
                                                   expect_out("busy_flush3", FREEZE, 32'h500);
        step(); ex_flush = 1'b0;                   expect_out("wait3", FREEZE, 32'h500);
        step(); rstn = 1'b0;                       expect_out("rst_in_wait", RST_CTL, 32'h0);
        expect_cnt("rst_in_wait", 0, 0);
        step(); mem_busy = 1'b0; rstn = 1'b1; ex_target = 32'h600;
                                                   expect_out("post_rst", DEF, 32'h600);
        step();                                    expect_out("post_rst_no_redir", DEF, 32'h600);

        // Counter scenario: 2 load-use stalls, 3 frozen cycles, 1 flush
        step(); load_use_rs1(5'd3);                expect_out("perf_ldu1", LDU, 32'h600);
        step(); idle();                            expect_out("perf_gap1", DEF, 32'h600);
        step(); load_use_rs1(5'd4);                expect_out("perf_ldu2", LDU, 32'h600);
        step(); idle();                            expect_out("perf_gap2", DEF, 32'h600);
        step(); mem_busy = 1'b1;                   expect_out("perf_busy1", FREEZE, 32'h600);
        step();                                    expect_out("perf_busy2", FREEZE, 32'h600);
        step(); mem_busy = 1'b0;                   expect_out("perf_exit", FREEZE, 32'h600);
        step();                                    expect_out("perf_run", DEF, 32'h600);
        step(); ex_flush = 1'b1; ex_target = 32'h700;
                                                   expect_out("perf_flush", FLUSH, 32'h700);
        step(); idle();                            expect_out("perf_end", DEF, 32'h700);
        expect_cnt("cnt_perf", 5, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
